// File: rtl/uart_rx.sv
// UART receiver: 8 data bits MSB first, one parity bit (even/odd selectable),
// one stop bit. The rx line is resynchronized and every line sample is taken
// near the middle of a bit, counted from the confirmed middle of the start bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 27,
  parameter int MID_SAMPLE   = 13
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic       rx,
  input  logic       parity_type,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam logic [4:0] LAST_CNT = 5'(CLKS_PER_BIT - 1);
  localparam logic [4:0] MID_CNT  = 5'(MID_SAMPLE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t     state;
  logic [4:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic       par_sel;
  logic       p_bad;
  logic       rx_meta;
  logic       rx_s;

  // Parity bit is wrong when it differs from the data XOR-reduction
  // folded with the selected sense (0 = even, 1 = odd).
  function automatic logic parity_bad(input logic [7:0] data,
                                      input logic       sel,
                                      input logic       pbit);
    return pbit != ((^data) ^ sel);
  endfunction

  // Two-flop synchronizer; idle-high so reset cannot look like a start bit.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Frame FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk_3125) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 5'd0;
      bit_idx    <= 3'd0;
      shreg      <= 8'h00;
      par_sel    <= 1'b0;
      p_bad      <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            cnt     <= 5'd0;
            par_sel <= parity_type;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == MID_CNT) begin
            cnt <= 5'd0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 3'd0;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        DATA: begin
          if (cnt == LAST_CNT) begin
            cnt   <= 5'd0;
            shreg <= {shreg[6:0], rx_s};
            if (bit_idx == 3'd7) begin
              state <= PARITY;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        PARITY: begin
          if (cnt == LAST_CNT) begin
            cnt   <= 5'd0;
            p_bad <= parity_bad(shreg, par_sel, rx_s);
            state <= STOP;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        STOP: begin
          if (cnt == LAST_CNT) begin
            cnt        <= 5'd0;
            rx_data    <= shreg;
            parity_err <= p_bad;
            frame_err  <= !rx_s;
            rx_valid   <= 1'b1;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              // Broken stop bit: wait for the line to recover before rearming.
              state <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        WAIT_HIGH: begin
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= 5'd0;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: clean frames, parity and framing errors,
// start-bit glitch, mid-frame reset and back-to-back frames at a fast bit time.
module tb_uart_rx;

  logic       clk_3125 = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       parity_type = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       rx_busy;

  int tests_run = 0;
  int tests_failed = 0;

  int valid_cnt = 0;
  int wide_cnt = 0;
  int err_cnt = 0;
  logic prev_valid = 1'b0;
  logic [7:0] got_q[$];

  uart_rx #(.CLKS_PER_BIT(27), .MID_SAMPLE(13)) dut (
    .clk_3125   (clk_3125),
    .rst        (rst),
    .rx         (rx),
    .parity_type(parity_type),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  // 3125 kHz clock (320 ns period).
  always #160 clk_3125 = ~clk_3125;

  // Pulse monitor on the falling edge: counts pulses, over-long pulses, errors.
  always @(negedge clk_3125) begin
    if (rx_valid) begin
      valid_cnt++;
      got_q.push_back(rx_data);
      if (parity_err || frame_err) err_cnt++;
      if (prev_valid) wide_cnt++;
    end
    prev_valid = rx_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic b, input int cycles);
    rx = b;
    repeat (cycles) begin
      @(posedge clk_3125);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int bt);
    drive_bit(1'b0, bt);
    for (int i = 7; i >= 0; i--) drive_bit(d[i], bt);
    drive_bit(pbit, bt);
    drive_bit(sbit, bt);
  endtask

  int v0;
  int e0;
  logic [7:0] exp_b2b [3];

  initial begin
    exp_b2b[0] = 8'h00;
    exp_b2b[1] = 8'hFF;
    exp_b2b[2] = 8'h55;

    repeat (3) begin
      @(posedge clk_3125);
      #1;
    end
    rst = 1'b0;
    drive_bit(1'b1, 5);
    check_eq("reset_data", 32'(rx_data), 32'h00);
    check_eq("reset_valid", 32'(rx_valid), 32'h0);
    check_eq("reset_busy", 32'(rx_busy), 32'h0);
    check_eq("reset_perr", 32'(parity_err), 32'h0);
    check_eq("reset_ferr", 32'(frame_err), 32'h0);

    // 0xA5, even parity, parity bit 0.
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b0, 1'b1, 27);
    drive_bit(1'b1, 10);
    check_eq("a5_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_perr", 32'(parity_err), 32'h0);
    check_eq("a5_ferr", 32'(frame_err), 32'h0);
    check_eq("a5_busy", 32'(rx_busy), 32'h0);

    // 0x07, odd parity latched at start; parity_type flips mid-frame.
    parity_type = 1'b1;
    v0 = valid_cnt;
    fork
      send_frame(8'h07, 1'b0, 1'b1, 27);
      begin
        repeat (60) @(posedge clk_3125);
        #2 parity_type = 1'b0;
      end
    join
    drive_bit(1'b1, 10);
    check_eq("odd_ok_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("odd_ok_data", 32'(rx_data), 32'h07);
    check_eq("odd_ok_perr", 32'(parity_err), 32'h0);

    // Same frame with a wrong parity bit.
    parity_type = 1'b1;
    v0 = valid_cnt;
    send_frame(8'h07, 1'b1, 1'b1, 27);
    drive_bit(1'b1, 10);
    check_eq("odd_bad_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("odd_bad_data", 32'(rx_data), 32'h07);
    check_eq("odd_bad_perr", 32'(parity_err), 32'h1);
    check_eq("odd_bad_ferr", 32'(frame_err), 32'h0);
    parity_type = 1'b0;

    // 5-cycle low glitch in idle.
    v0 = valid_cnt;
    drive_bit(1'b0, 5);
    drive_bit(1'b1, 3);
    check_eq("glitch_busy_mid", 32'(rx_busy), 32'h1);
    drive_bit(1'b1, 10);
    check_eq("glitch_busy_end", 32'(rx_busy), 32'h0);
    drive_bit(1'b1, 20);
    check_eq("glitch_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_eq("glitch_data", 32'(rx_data), 32'h07);
    check_eq("glitch_perr", 32'(parity_err), 32'h1);
    check_eq("glitch_ferr", 32'(frame_err), 32'h0);

    // 0x3C with a low stop bit, line held low for 60 more cycles.
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, 27);
    drive_bit(1'b0, 60);
    check_eq("ferr_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("ferr_data", 32'(rx_data), 32'h3C);
    check_eq("ferr_flag", 32'(frame_err), 32'h1);
    check_eq("ferr_perr", 32'(parity_err), 32'h0);
    check_eq("ferr_busy_low", 32'(rx_busy), 32'h1);
    drive_bit(1'b1, 6);
    check_eq("ferr_busy_high", 32'(rx_busy), 32'h0);
    drive_bit(1'b1, 40);
    check_eq("ferr_no_second", 32'(valid_cnt - v0), 32'd1);

    // Reset pulsed in the middle of data bit 4 of 0xFF.
    v0 = valid_cnt;
    drive_bit(1'b0, 27);
    drive_bit(1'b1, 27 * 4 + 13);
    rst = 1'b1;
    drive_bit(1'b1, 2);
    rst = 1'b0;
    drive_bit(1'b1, 320);
    check_eq("rst_valid_cnt", 32'(valid_cnt - v0), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'h00);
    check_eq("rst_perr", 32'(parity_err), 32'h0);
    check_eq("rst_ferr", 32'(frame_err), 32'h0);
    check_eq("rst_busy", 32'(rx_busy), 32'h0);
    v0 = valid_cnt;
    send_frame(8'h81, 1'b0, 1'b1, 27);
    drive_bit(1'b1, 10);
    check_eq("post_rst_valid_cnt", 32'(valid_cnt - v0), 32'd1);
    check_eq("post_rst_data", 32'(rx_data), 32'h81);

    // Back-to-back frames from a 26-cycle transmitter.
    got_q.delete();
    v0 = valid_cnt;
    e0 = err_cnt;
    send_frame(8'h00, 1'b0, 1'b1, 26);
    send_frame(8'hFF, 1'b0, 1'b1, 26);
    send_frame(8'h55, 1'b0, 1'b1, 26);
    drive_bit(1'b1, 20);
    check_eq("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd3);
    check_eq("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("b2b_data%0d", i),
               (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_b2b[i]));
    end

    check_eq("valid_one_cycle", 32'(wide_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
